// File: rtl/sm_to_tc_pipe.sv
// sm_to_tc_pipe: two-stage elastic sign-magnitude to two's-complement converter with negative-zero stats
module sm_to_tc_pipe #(
    parameter int W  = 10,
    parameter int N  = 4,
    parameter int CW = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_sign,
    input  logic [N*(W-1)-1:0] in_mag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*W-1:0]     out_data,
    input  logic               clr_stats,
    output logic               nz_sticky,
    output logic [CW-1:0]      nz_count
);
    localparam int KW = $clog2(N + 1);
    logic               s1_valid_q, s1_valid_d;
    logic [N-1:0]       s1_sign_q, s1_sign_d;
    logic [N*(W-1)-1:0] s1_mag_q, s1_mag_d;
    logic               s2_valid_q, s2_valid_d;
    logic [N*W-1:0]     s2_data_q, s2_data_d;
    logic               nz_sticky_q, nz_sticky_d;
    logic [CW-1:0]      nz_count_q, nz_count_d;
    logic               s2_adv, s1_adv, in_fire;
    logic [N*W-1:0]     conv;
    logic [KW-1:0]      k;
    logic [CW:0]        sum;
    always_comb begin
        s2_adv   = ~s2_valid_q | out_ready;
        s1_adv   = s1_valid_q & s2_adv;
        in_ready = ~s1_valid_q | s2_adv;
        in_fire  = in_valid & in_ready;
        conv     = '0;
        k        = '0;
        // negating a zero magnitude wraps to 0, so negative zero canonicalises for free
        for (int i = 0; i < N; i++) begin
            conv[i*W +: W] = s1_sign_q[i] ? W'(~{1'b0, s1_mag_q[i*(W-1) +: W-1]} + 1'b1)
                                          : {1'b0, s1_mag_q[i*(W-1) +: W-1]};
            k = k + KW'(s1_sign_q[i] & ~|s1_mag_q[i*(W-1) +: W-1]);
        end
        sum         = {1'b0, nz_count_q} + (CW+1)'(k);
        nz_count_d  = clr_stats ? '0 : s1_adv ? (sum[CW] ? '1 : sum[CW-1:0]) : nz_count_q;
        nz_sticky_d = ~clr_stats & (nz_sticky_q | (s1_adv & (k != '0)));
        s1_valid_d  = in_fire | (s1_valid_q & ~s1_adv);
        s1_sign_d   = in_fire ? in_sign : s1_sign_q;
        s1_mag_d    = in_fire ? in_mag : s1_mag_q;
        s2_valid_d  = s1_adv | (s2_valid_q & ~out_ready);
        s2_data_d   = s1_adv ? conv : s2_data_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= '0;
            s1_mag_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            nz_sticky_q <= 1'b0;
            nz_count_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_mag_q    <= s1_mag_d;
            s2_valid_q  <= s2_valid_d;
            s2_data_q   <= s2_data_d;
            nz_sticky_q <= nz_sticky_d;
            nz_count_q  <= nz_count_d;
        end
    end
    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
    assign nz_sticky = nz_sticky_q;
    assign nz_count  = nz_count_q;
endmodule

// File: tb/tb_sm_to_tc_pipe.sv
// tb_sm_to_tc_pipe: directed checks of the sm_to_tc_pipe converter, handshake and stats
module tb_sm_to_tc_pipe;
    localparam int W = 10, N = 4, CW = 4;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [N-1:0]      in_sign = '0;
    logic [N*(W-1)-1:0] in_mag = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [N*W-1:0]    out_data;
    logic              clr_stats = 1'b0;
    logic              nz_sticky;
    logic [CW-1:0]     nz_count;
    int checks = 0, errors = 0;
    logic [3:0]  bs [9];
    logic [35:0] bm [9];
    logic [39:0] ex [9];
    sm_to_tc_pipe #(.W(W), .N(N), .CW(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_mag(in_mag), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .clr_stats(clr_stats),
        .nz_sticky(nz_sticky), .nz_count(nz_count)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask
    function automatic logic [9:0] model(input logic s, input logic [8:0] m);
        return s ? 10'(1024 - int'(m)) : 10'(m);
    endfunction
    initial begin
        int sent, rcv;
        logic acc, ot;
        tick();
        tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_nz_count", nz_count, 0);
        chk("rst_nz_sticky", nz_sticky, 0);
        rst = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        // lanes: -511, -1, +300, +0
        in_valid = 1'b1;
        in_sign  = 4'b0011;
        in_mag   = {9'd0, 9'd300, 9'd1, 9'd511};
        tick();
        in_valid = 1'b0;
        chk("lat1_out_valid", out_valid, 0);
        tick();
        chk("lat2_out_valid", out_valid, 1);
        chk("conv_basic", out_data, {10'h000, 10'h12C, 10'h3FF, 10'h201});
        chk("pos_zero_nz_count", nz_count, 0);
        tick();
        chk("drain_out_valid", out_valid, 0);
        in_valid = 1'b1;
        in_sign  = 4'b0101;
        in_mag   = '0;
        tick();
        in_valid = 1'b0;
        tick();
        chk("nz_data", out_data, 0);
        chk("nz_count2", nz_count, 2);
        chk("nz_sticky_set", nz_sticky, 1);
        tick();
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("clr_count", nz_count, 0);
        chk("clr_sticky", nz_sticky, 0);
        for (int b = 0; b < 9; b++) begin
            bs[b] = 4'(b) ^ 4'b1010;
            for (int i = 0; i < N; i++) begin
                bm[b][i*9 +: 9] = 9'(b*4 + i + 1);
                ex[b][i*10 +: 10] = model(bs[b][i], 9'(b*4 + i + 1));
            end
        end
        sent = 0;
        rcv = 0;
        for (int c = 0; c < 40 && rcv < 8; c++) begin
            in_valid  = sent < 8;
            in_sign   = bs[sent];
            in_mag    = bm[sent];
            out_ready = !(c >= 3 && c <= 7);
            #1;
            if (c == 3 || c == 7) chk("stall_in_ready", in_ready, 0);
            if (out_valid) chk(out_ready ? "stream_data" : "stall_hold", out_data, ex[rcv]);
            acc = in_valid & in_ready;
            ot  = out_valid & out_ready;
            @(posedge clk);
            sent += int'(acc);
            rcv  += int'(ot);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", rcv, 8);
        tick();
        chk("stream_no_dup", out_valid, 0);
        chk("stream_nz_none", nz_count, 0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sign   = 4'b0001;
        in_mag    = '0;
        tick();
        in_sign   = 4'b0000;
        in_mag    = {9'd4, 9'd3, 9'd2, 9'd1};
        tick();
        in_valid = 1'b0;
        #1;
        chk("full_in_ready", in_ready, 0);
        chk("full_nz_count", nz_count, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_nz_count", nz_count, 0);
        chk("midrst_nz_sticky", nz_sticky, 0);
        out_ready = 1'b1;
        tick();
        chk("midrst_gone1", out_valid, 0);
        tick();
        chk("midrst_gone2", out_valid, 0);
        in_valid = 1'b1;
        in_sign  = 4'b0001;
        in_mag   = {9'd7, 9'd7, 9'd7, 9'd0};
        for (int b = 0; b < 20; b++) tick();
        in_valid = 1'b0;
        chk("sat_data", out_data, {10'd7, 10'd7, 10'd7, 10'd0});
        tick();
        tick();
        chk("sat_nz_count", nz_count, 15);
        chk("sat_nz_sticky", nz_sticky, 1);
        in_valid = 1'b1;
        tick();
        in_valid  = 1'b0;
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("clr_race_count", nz_count, 0);
        chk("clr_race_sticky", nz_sticky, 0);
        chk("clr_race_valid", out_valid, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
